// File: rtl/mem_access_if.sv
//------------------------------------------------------------------------------
// Module      : mem_access_if
// Description : Request/response handshake bundle between the datapath and
//               the RAM access controller.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_access_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_W      = 2
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [LEN_W-1:0]      req_len;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_last;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_last
    );
endinterface

`default_nettype wire

// File: rtl/mem_access_ctrl.sv
//------------------------------------------------------------------------------
// Module      : mem_access_ctrl
// Description : Load/store front end for a single-port RAM with burst reads
//               and a backpressured response channel.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_W      = 2
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    mem_access_if.slave                bus,
    output      logic                  busy,
    output      logic [ADDR_WIDTH-1:0] mem_address,
    output      logic [DATA_WIDTH-1:0] mem_data,
    output      logic                  mem_we,
    output      logic                  mem_re,
    input  wire logic [DATA_WIDTH-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_RD_ISSUE = 2'd2,
        ST_RD_RESP  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [LEN_W-1:0]      r_remaining;
    logic [DATA_WIDTH-1:0] r_rsp_data;

    logic                  w_accept;
    logic                  w_beat_done;
    logic                  w_last_beat;
    logic                  w_req_ready;
    logic                  w_rsp_valid;
    logic                  w_mem_we;
    logic                  w_mem_re;

    assign w_last_beat = (r_remaining == '0);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_beat_done = w_rsp_valid && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_next = bus.req_write ? ST_WRITE : ST_RD_ISSUE;
                end
            end
            ST_WRITE: begin
                w_mem_we     = 1'b1;
                w_state_next = ST_IDLE;
            end
            ST_RD_ISSUE: begin
                w_mem_re     = 1'b1;
                w_state_next = ST_RD_RESP;
            end
            ST_RD_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_next = w_last_beat ? ST_IDLE : ST_RD_ISSUE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Burst bookkeeping advances only when a non-final beat is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr      <= '0;
            r_wdata     <= '0;
            r_remaining <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_accept) begin
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_remaining <= bus.req_write ? '0 : bus.req_len;
            end else if (w_beat_done && !w_last_beat) begin
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (r_state == ST_RD_ISSUE) begin
                r_rsp_data <= mem_data_out;
            end
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_last  = w_rsp_valid && w_last_beat;
    assign busy          = (r_state != ST_IDLE);
    assign mem_address   = r_addr;
    assign mem_data      = r_wdata;
    assign mem_we        = w_mem_we;
    assign mem_re        = w_mem_re;

endmodule

`default_nettype wire
